// File: rtl/mult_digit_sched_pkg.sv
// Shared types and sizing helpers for the digit-serial multiplier scheduler.
// The core multiplies one 2-bit digit of each operand per cycle.
package mult_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DIGIT_W = 2;

  function automatic int num_digits(input int width);
    return width / DIGIT_W;
  endfunction

  function automatic int idx_width(input int width);
    int d;
    d = width / DIGIT_W;
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/mult_digit_sched_if.sv
// Operand/result handshake bundle between a requesting datapath and the scheduler.
interface mult_digit_sched_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mult_digit_sched_mul2x2_core.sv
// Combinational unsigned 2x2->4 multiplier; the slot where generated
// 2x2 architectures are dropped in.
module mul2x2_core
  import mult_sched_pkg::*;
(
  input  logic [DIGIT_W-1:0]   x_i,
  input  logic [DIGIT_W-1:0]   y_i,
  output logic [2*DIGIT_W-1:0] prod_o
);
  assign prod_o = {{DIGIT_W{1'b0}}, x_i} * {{DIGIT_W{1'b0}}, y_i};
endmodule

// File: rtl/mult_digit_sched.sv
// Digit-serial WIDTHxWIDTH unsigned multiplier: walks every digit pair (i, j)
// through one 2x2 core and accumulates the shifted partial products.
module mult_digit_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mult_digit_sched_if.slave bus
);
  localparam int D  = num_digits(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [PW-1:0]        acc_q, acc_d;
  logic                 load;
  logic [DIGIT_W-1:0]   a_dig, b_dig;
  logic [2*DIGIT_W-1:0] pp;
  logic [IW:0]          dsum;
  logic [PW-1:0]        pp_sh;

  assign a_dig = a_q[{i_q, 1'b0} +: DIGIT_W];
  assign b_dig = b_q[{j_q, 1'b0} +: DIGIT_W];

  mul2x2_core u_core (
    .x_i    (a_dig),
    .y_i    (b_dig),
    .prod_o (pp)
  );

  // Digit pair (i, j) carries weight 4^(i+j), i.e. a shift of 2*(i+j).
  assign dsum  = {1'b0, i_q} + {1'b0, j_q};
  assign pp_sh = PW'(pp) << {dsum, 1'b0};

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp_sh;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
    end
  end

  // Operand registers are pure data and only need a load enable.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.p         = acc_q;

endmodule

// File: tb/tb_mult_digit_sched.sv
// Bench for mult_digit_sched at WIDTH=2, 8 and 16 with directed scenarios and
// a queue-based reference model of a*b for randomized back-to-back traffic.
module tb_mult_digit_sched;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_digit_sched_if #(.WIDTH(2))  i2 ();
  mult_digit_sched_if #(.WIDTH(8))  i8 ();
  mult_digit_sched_if #(.WIDTH(16)) i16 ();

  mult_digit_sched #(.WIDTH(2))  dut2  (.clk(clk), .rst(rst), .bus(i2));
  mult_digit_sched #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(i8));
  mult_digit_sched #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic r);
    if (w == 8) begin
      i8.in_valid = v; i8.a = a[7:0]; i8.b = b[7:0]; i8.out_ready = r;
    end else begin
      i16.in_valid = v; i16.a = a; i16.b = b; i16.out_ready = r;
    end
  endtask

  function automatic logic get_ir(input int w);
    return (w == 8) ? i8.in_ready : i16.in_ready;
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 8) ? i8.out_valid : i16.out_valid;
  endfunction

  function automatic logic [31:0] get_p(input int w);
    return (w == 8) ? 32'(i8.p) : i16.p;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    i8.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i8.in_valid = (k == 0);
      i8.a = 8'($urandom);
      i8.b = 8'($urandom);
      tick();
      checks++; if (i8.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", i8.in_ready); end
      checks++; if (i8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", i8.out_valid); end
      checks++; if (i8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", i8.busy); end
      checks++; if (i8.p !== 16'h0) begin errors++; $display("FAIL reset_p got %h want 0000", i8.p); end
    end
    rst = 1'b0;
    i8.in_valid = 1'b0;
    tick();
    checks++; if (i8.in_ready !== 1'b1 || i8.out_valid !== 1'b0 || i8.busy !== 1'b0 || i8.p !== 16'h0) begin
      errors++; $display("FAIL release_idle got ir=%b ov=%b busy=%b p=%h want 1 0 0 0000", i8.in_ready, i8.out_valid, i8.busy, i8.p);
    end
    checks++; if (i2.in_ready !== 1'b1 || i2.p !== 4'h0) begin
      errors++; $display("FAIL reset_w2 got ir=%b p=%h want 1 0", i2.in_ready, i2.p);
    end
    checks++; if (i16.in_ready !== 1'b1 || i16.p !== 32'h0) begin
      errors++; $display("FAIL reset_w16 got ir=%b p=%h want 1 0", i16.in_ready, i16.p);
    end
  endtask

  task automatic test_full_scale();
    int n;
    i8.a = 8'hFF; i8.b = 8'hFF; i8.out_ready = 1'b1; i8.in_valid = 1'b1;
    tick();
    i8.in_valid = 1'b0;
    checks++; if (i8.busy !== 1'b1 || i8.in_ready !== 1'b0) begin
      errors++; $display("FAIL full_run_flags got busy=%b ir=%b want 1 0", i8.busy, i8.in_ready);
    end
    n = 0;
    while (i8.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL full_latency got %0d want 16", n); end
    checks++; if (i8.p !== 16'hFE01) begin errors++; $display("FAIL full_p got %h want fe01", i8.p); end
    tick();
    checks++; if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1) begin
      errors++; $display("FAIL full_return_idle got ov=%b ir=%b want 0 1", i8.out_valid, i8.in_ready);
    end
    i8.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic bad;
    i8.a = 8'h12; i8.b = 8'h34; i8.out_ready = 1'b0; i8.in_valid = 1'b1;
    tick();
    i8.a = 8'hFF; i8.b = 8'hFF;
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (i8.in_ready !== 1'b0 || i8.out_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_run_flags got ir/ov high during run want both 0"); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (i8.out_valid !== 1'b1 || i8.p !== 16'h03A8 || i8.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got ov=%b p=%h ir=%b want 1 03a8 0", k, i8.out_valid, i8.p, i8.in_ready);
      end
      tick();
    end
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    checks++; if (i8.out_valid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %b want 1", i8.out_valid); end
    tick();
    i8.out_ready = 1'b0;
    checks++; if (i8.out_valid !== 1'b0 || i8.in_ready !== 1'b1 || i8.p !== 16'h03A8) begin
      errors++; $display("FAIL bp_after got ov=%b ir=%b p=%h want 0 1 03a8", i8.out_valid, i8.in_ready, i8.p);
    end
    tick();
    checks++; if (i8.busy !== 1'b0 || i8.p !== 16'h03A8) begin
      errors++; $display("FAIL bp_extra_ignored got busy=%b p=%h want 0 03a8", i8.busy, i8.p);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int n;
    i8.a = 8'hA5; i8.b = 8'h5A; i8.out_ready = 1'b1; i8.in_valid = 1'b1;
    tick();
    i8.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (i8.out_valid !== 1'b0 || i8.busy !== 1'b0 || i8.in_ready !== 1'b1 || i8.p !== 16'h0) begin
      errors++; $display("FAIL mid_reset got ov=%b busy=%b ir=%b p=%h want 0 0 1 0000", i8.out_valid, i8.busy, i8.in_ready, i8.p);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (i8.out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_output got out_valid=1 want 0"); end
    i8.a = 8'h00; i8.b = 8'hAB; i8.in_valid = 1'b1;
    tick();
    i8.in_valid = 1'b0;
    n = 0;
    while (i8.out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL mid_job2_latency got %0d want 16", n); end
    checks++; if (i8.p !== 16'h0000) begin errors++; $display("FAIL mid_job2_p got %h want 0000", i8.p); end
    tick();
    i8.out_ready = 1'b0;
  endtask

  task automatic test_min_width();
    int n;
    i2.a = 2'd3; i2.b = 2'd3; i2.out_ready = 1'b1; i2.in_valid = 1'b1;
    tick();
    i2.in_valid = 1'b0;
    n = 0;
    while (i2.out_valid !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL w2_latency got %0d want 1", n); end
    checks++; if (i2.p !== 4'd9) begin errors++; $display("FAIL w2_p got %0d want 9", i2.p); end
    tick();
    checks++; if (i2.in_ready !== 1'b1 || i2.out_valid !== 1'b0) begin
      errors++; $display("FAIL w2_idle got ir=%b ov=%b want 1 0", i2.in_ready, i2.out_valid);
    end
  endtask

  task automatic test_random(input int w, input int n);
    longint unsigned exp_q[$];
    int              acc_slot[$];
    int              issued, got, slot, dd;
    logic [15:0]     ra, rb;
    logic            v, r, ov_prev, ov;
    longint unsigned want;
    issued = 0; got = 0; slot = 0; ov_prev = 1'b0;
    dd = (w / 2) * (w / 2);
    while (got < n && slot < n * (dd + 12)) begin
      v  = (issued < n) && ($urandom_range(0, 3) != 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (w == 8) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
      r  = ($urandom_range(0, 3) != 0);
      set_in(w, v, ra, rb, r);
      ov = get_ov(w);
      if (get_ir(w) && v) begin
        exp_q.push_back(longint'(ra) * longint'(rb));
        acc_slot.push_back(slot);
        issued++;
      end
      if (ov) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand%0d_unexpected got out_valid=1 want 0", w);
        end else begin
          if (!ov_prev) begin
            checks++; if (slot - acc_slot[0] != dd + 1) begin
              errors++; $display("FAIL rand%0d_latency got %0d want %0d", w, slot - acc_slot[0] - 1, dd);
            end
          end
          if (r) begin
            want = exp_q.pop_front();
            void'(acc_slot.pop_front());
            got++;
            checks++; if (64'(get_p(w)) !== want) begin
              errors++; $display("FAIL rand%0d_p #%0d got %h want %h", w, got, get_p(w), want);
            end
          end
        end
      end
      ov_prev = ov && !r;
      tick();
      slot++;
    end
    set_in(w, 1'b0, 16'h0, 16'h0, 1'b0);
    checks++; if (got != n) begin
      errors++; $display("FAIL rand%0d_timeout got %0d results want %0d", w, got, n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    i2.in_valid = 1'b0;  i2.a = '0;  i2.b = '0;  i2.out_ready = 1'b0;
    i8.in_valid = 1'b0;  i8.a = '0;  i8.b = '0;  i8.out_ready = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.out_ready = 1'b0;
    test_reset();
    test_full_scale();
    test_backpressure();
    test_reset_mid();
    test_min_width();
    fork
      test_random(8, 500);
      test_random(16, 500);
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
